mac_array: RTL and testbench

//  Matrix-multiply engine: OUT(TxM) = IN(TxN) x W(NxM), int8 operands, 16-bit results, M,N,T in 1..8.

---
 rtl/mac_array_pkg.sv | 46 ++++
 rtl/mac_pe.sv | 68 ++++++
 rtl/mac_array.sv | 217 +++++++++++++++++++++
 tb/tb_mac_array.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_array_pkg                                             |
// | Purpose  : Shared constants, FSM state encoding and element helpers  |
// |            for the mac_array matrix-multiply engine.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mac_array_pkg;

    // Operand element width (signed int8)
    localparam int c_dw  = 8;
    // Result element width
    localparam int c_ow  = 16;
    // Max matrix dimension; also elements per 64-bit SRAM word
    localparam int c_dim = 8;
    // Full-precision dot-product width: 16b products summed over 8 lanes
    localparam int c_sw  = 2 * c_dw + $clog2(c_dim);
    // Number of processing elements (results per output word)
    localparam int c_npe = 4;

    // Pass sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDW  = 3'd1,
        ST_RDI  = 3'd2,
        ST_CAP  = 3'd3,
        ST_WLO  = 3'd4,
        ST_WHI  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Element k of a packed word; element 0 sits in the most significant byte
    function automatic logic signed [c_dw-1:0] elem(
        input logic [c_dw*c_dim-1:0] word,
        input int unsigned           k
    );
        return word[c_dw*c_dim-1-c_dw*k -: c_dw];
    endfunction

    // Dimension fields above the hardware maximum are treated as the maximum
    function automatic logic [3:0] clamp_dim(input logic [3:0] f);
        return (f > 4'd8) ? 4'd8 : f;
    endfunction

endpackage : mac_array_pkg
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_pe                                                    |
// | Purpose  : 8-lane signed int8 dot product with per-lane enable.      |
// |            Build option MAC_SATURATE_EN clamps the sum to the int16  |
// |            range; otherwise the sum wraps to 16 bits.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mac_pe
    import mac_array_pkg::*;
(
    input  logic [c_dim-1:0]      lane_en,
    input  logic [c_dw*c_dim-1:0] a_word,
    input  logic [c_dw*c_dim-1:0] b_word,
    output logic [c_ow-1:0]       result
);

`ifdef MAC_SATURATE_EN
    // Keep full precision so overflow can be detected before clamping
    localparam int c_acc_w = c_sw;
`else
    // Wrapping result: summing modulo 2^16 equals truncating the full sum
    localparam int c_acc_w = c_ow;
`endif

    logic signed [2*c_dw-1:0]  w_prod [c_dim];
    logic signed [c_acc_w-1:0] w_sum;

    genvar k;
    generate
        for (k = 0; k < c_dim; k++) begin : g_lane
            logic signed [c_dw-1:0] w_a;
            logic signed [c_dw-1:0] w_b;
            assign w_a       = elem(a_word, k);
            // A disabled lane multiplies by zero so it adds nothing
            assign w_b       = lane_en[k] ? elem(b_word, k) : '0;
            assign w_prod[k] = w_a * w_b;
        end
    endgenerate

    // Adder tree over the eight sign-extended lane products
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_dim; i++) begin
            w_sum = w_sum + c_acc_w'(w_prod[i]);
        end
    end

`ifdef MAC_SATURATE_EN
    localparam logic signed [c_sw-1:0] c_sat_max = c_sw'(2 ** (c_ow - 1) - 1);
    localparam logic signed [c_sw-1:0] c_sat_min = c_sw'(-(2 ** (c_ow - 1)));

    // Clamp the full-precision sum into the signed 16-bit range
    always_comb begin
        if (w_sum > c_sat_max) begin
            result = {1'b0, {(c_ow-1){1'b1}}};
        end else if (w_sum < c_sat_min) begin
            result = {1'b1, {(c_ow-1){1'b0}}};
        end else begin
            result = w_sum[c_ow-1:0];
        end
    end
`else
    assign result = w_sum;
`endif

endmodule : mac_pe
`default_nettype wire

// File: rtl/mac_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_array                                                 |
// | Purpose  : OUT(TxM) = IN(TxN) x W(NxM) engine between input, weight  |
// |            and output SRAMs using four dot-product PEs. One pass per |
// |            START. Build option MAC_SATURATE_EN selects saturating    |
// |            instead of wrapping 16-bit results.                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mac_array
    import mac_array_pkg::*;
#(
    parameter int DW  = c_dw,
    parameter int OW  = c_ow,
    parameter int DIM = c_dim
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      START,
    input  logic [11:0]               MNT,
    output logic                      EN_W,
    output logic [$clog2(DIM)-1:0]    ADDR_W,
    input  logic [DW*DIM-1:0]         RDATA_W,
    output logic                      EN_I,
    output logic [$clog2(DIM)-1:0]    ADDR_I,
    input  logic [DW*DIM-1:0]         RDATA_I,
    output logic                      EN_O,
    output logic                      RW_O,
    output logic [$clog2(2*DIM)-1:0]  ADDR_O,
    output logic [c_npe*OW-1:0]       WDATA_O,
    input  logic [c_npe*OW-1:0]       RDATA_O
);

    // Sequencer state
    state_e                   r_state;
    logic [3:0]               r_cnt;
    logic [2:0]               r_t;
    logic [3:0]               r_m;
    logic [3:0]               r_n;
    logic [3:0]               r_t_lim;

    // Registered SRAM controls
    logic                     r_en_w;
    logic [2:0]               r_addr_w;
    logic                     r_en_i;
    logic [2:0]               r_addr_i;
    logic                     r_en_o;
    logic                     r_rw_o;
    logic [3:0]               r_addr_o;

    // Operand storage
    logic                     r_wcap_vld;
    logic [2:0]               r_wcap_addr;
    logic [DW*DIM-1:0]        r_wrf [DIM];
    logic [DW*DIM-1:0]        r_in_row;

    // Datapath
    logic [DIM-1:0]           w_lane_en;
    logic                     w_row_ok;
    logic [c_npe*OW-1:0]      w_pack;
    logic                     w_unused_rdata_o;

    // The output SRAM is write-only from this block
    assign w_unused_rdata_o = ^RDATA_O;

    // Pass sequencer: launches on START in IDLE, walks weight load then rows
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_t      <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_t_lim  <= '0;
            r_en_w   <= 1'b0;
            r_addr_w <= '0;
            r_en_i   <= 1'b0;
            r_addr_i <= '0;
            r_en_o   <= 1'b0;
            r_rw_o   <= 1'b0;
            r_addr_o <= '0;
            r_in_row <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_m      <= clamp_dim(MNT[11:8]);
                        r_n      <= clamp_dim(MNT[7:4]);
                        r_t_lim  <= clamp_dim(MNT[3:0]);
                        r_t      <= '0;
                        r_cnt    <= '0;
                        r_en_w   <= 1'b1;
                        r_addr_w <= '0;
                        r_state  <= ST_LDW;
                    end
                end
                ST_LDW: begin
                    // Eight row reads, the last capture lands at cnt 8,
                    // and cnt 9 is a settling cycle before the first row fetch
                    if (r_cnt == 4'd9) begin
                        r_en_i   <= 1'b1;
                        r_addr_i <= r_t;
                        r_state  <= ST_RDI;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt < 4'd7) begin
                            r_en_w   <= 1'b1;
                            r_addr_w <= r_cnt[2:0] + 3'd1;
                        end else begin
                            r_en_w   <= 1'b0;
                            r_addr_w <= '0;
                        end
                    end
                end
                ST_RDI: begin
                    r_en_i   <= 1'b0;
                    r_addr_i <= '0;
                    r_state  <= ST_CAP;
                end
                ST_CAP: begin
                    r_in_row <= RDATA_I;
                    r_en_o   <= 1'b1;
                    r_rw_o   <= 1'b1;
                    r_addr_o <= {r_t, 1'b0};
                    r_state  <= ST_WLO;
                end
                ST_WLO: begin
                    r_addr_o <= {r_t, 1'b1};
                    r_state  <= ST_WHI;
                end
                ST_WHI: begin
                    r_en_o   <= 1'b0;
                    r_rw_o   <= 1'b0;
                    r_addr_o <= '0;
                    // Every row is written, masked rows simply produce zeros
                    if (r_t == 3'd7) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_t      <= r_t + 3'd1;
                        r_en_i   <= 1'b1;
                        r_addr_i <= r_t + 3'd1;
                        r_state  <= ST_RDI;
                    end
                end
                ST_DONE: begin
                    // Require START to drop so a held START runs only once
                    if (!START) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Weight rows arrive one cycle after their read; capture into the regfile
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            r_wcap_vld  <= 1'b0;
            r_wcap_addr <= '0;
            for (int i = 0; i < DIM; i++) begin
                r_wrf[i] <= '0;
            end
        end else begin
            r_wcap_vld  <= r_en_w;
            r_wcap_addr <= r_addr_w;
            if (r_wcap_vld) begin
                r_wrf[r_wcap_addr] <= RDATA_W;
            end
        end
    end

    assign w_row_ok = ({1'b0, r_t} < r_t_lim);

    genvar k;
    generate
        for (k = 0; k < DIM; k++) begin : g_lane_mask
            assign w_lane_en[k] = (4'(k) < r_n);
        end
    endgenerate

    genvar j;
    generate
        for (j = 0; j < c_npe; j++) begin : g_pe
            logic [DW*DIM-1:0] w_wrow;
            logic [3:0]        w_col;
            logic [OW-1:0]     w_res;

            // The low half of an output row uses columns 0..3, the high half 4..7
            assign w_wrow = r_addr_o[0] ? r_wrf[j + c_npe] : r_wrf[j];
            assign w_col  = {1'b0, r_addr_o[0], 2'(j)};

            mac_pe u_pe (
                .lane_en (w_lane_en),
                .a_word  (r_in_row),
                .b_word  (w_wrow),
                .result  (w_res)
            );

            assign w_pack[c_npe*OW-1-OW*j -: OW] =
                (w_row_ok && (w_col < r_m)) ? w_res : '0;
        end
    endgenerate

    assign EN_W    = r_en_w;
    assign ADDR_W  = r_addr_w;
    assign EN_I    = r_en_i;
    assign ADDR_I  = r_addr_i;
    assign EN_O    = r_en_o;
    assign RW_O    = r_rw_o;
    assign ADDR_O  = r_addr_o;
    assign WDATA_O = r_en_o ? w_pack : '0;

endmodule : mac_array
`default_nettype wire

// File: tb/tb_mac_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mac_array                                              |
// | Purpose  : Self-checking bench for mac_array with SRAM models and a  |
// |            matrix-product reference model (honours MAC_SATURATE_EN). |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_mac_array;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [11:0] MNT;
    logic        EN_W;
    logic [2:0]  ADDR_W;
    logic [63:0] RDATA_W = '0;
    logic        EN_I;
    logic [2:0]  ADDR_I;
    logic [63:0] RDATA_I = '0;
    logic        EN_O;
    logic        RW_O;
    logic [3:0]  ADDR_O;
    logic [63:0] WDATA_O;
    logic [63:0] RDATA_O = 64'h0123_4567_89AB_CDEF;

    logic [63:0] wmem    [8];
    logic [63:0] imem    [8];
    logic [63:0] omem    [16];
    logic [63:0] exp_mem [16];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int writes     = 0;
    int start_edge = -1;
    int first_ew   = -1;
    int last_wr    = -1;
    bit armed      = 1'b0;

    always #5 CLK = ~CLK;

    mac_array dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .MNT     (MNT),
        .EN_W    (EN_W),
        .ADDR_W  (ADDR_W),
        .RDATA_W (RDATA_W),
        .EN_I    (EN_I),
        .ADDR_I  (ADDR_I),
        .RDATA_I (RDATA_I),
        .EN_O    (EN_O),
        .RW_O    (RW_O),
        .ADDR_O  (ADDR_O),
        .WDATA_O (WDATA_O),
        .RDATA_O (RDATA_O)
    );

    // SRAM models and edge-numbered event recorder
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (armed && start_edge < 0 && START && !RSTN) start_edge = cyc;
        if (armed && first_ew < 0 && EN_W) first_ew = cyc;
        if (EN_O && RW_O) begin
            omem[ADDR_O] = WDATA_O;
            writes       = writes + 1;
            last_wr      = cyc;
        end
        if (EN_W) RDATA_W <= wmem[ADDR_W];
        if (EN_I) RDATA_I <= imem[ADDR_I];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain matrix product over the clamped dimensions
    task automatic build_expected(input logic [11:0] mnt);
        int m_l, n_l, t_l, acc;
        logic [63:0] a, b, word;
        logic [15:0] r;
        m_l = (mnt[11:8] > 4'd8) ? 8 : int'(mnt[11:8]);
        n_l = (mnt[7:4]  > 4'd8) ? 8 : int'(mnt[7:4]);
        t_l = (mnt[3:0]  > 4'd8) ? 8 : int'(mnt[3:0]);
        for (int w = 0; w < 16; w++) exp_mem[w] = '0;
        for (int t = 0; t < 8; t++) begin
            for (int m = 0; m < 8; m++) begin
                acc = 0;
                a = imem[t];
                b = wmem[m];
                if (t < t_l && m < m_l) begin
                    for (int k = 0; k < n_l; k++) begin
                        acc = acc + $signed(a[63-8*k -: 8]) * $signed(b[63-8*k -: 8]);
                    end
                end
`ifdef MAC_SATURATE_EN
                if (acc > 32767)       r = 16'h7FFF;
                else if (acc < -32768) r = 16'h8000;
                else                   r = 16'(acc);
`else
                r = 16'(acc);
`endif
                word = exp_mem[2*t + m/4];
                word[63-16*(m%4) -: 16] = r;
                exp_mem[2*t + m/4] = word;
            end
        end
    endtask

    task automatic fill(input logic [63:0] iv, input logic [63:0] wv);
        for (int i = 0; i < 8; i++) begin
            imem[i] = iv;
            wmem[i] = wv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            imem[i] = {$urandom, $urandom};
            wmem[i] = {$urandom, $urandom};
        end
    endtask

    task automatic run_pass(input logic [11:0] mnt, input bit hold, input string tag);
        int guard;
        for (int w = 0; w < 16; w++) omem[w] = 64'hA5A5_A5A5_A5A5_A5A5;
        writes = 0; start_edge = -1; first_ew = -1; last_wr = -1;
        build_expected(mnt);
        @(negedge CLK);
        armed = 1'b1;
        MNT   = mnt;
        START = 1'b1;
        guard = 0;
        while (start_edge < 0 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        if (!hold) START = 1'b0;
        // Configuration changes after launch must not matter
        MNT = 12'($urandom);
        guard = 0;
        while (writes < 16 && guard < 100) begin
            @(negedge CLK);
            guard++;
            if (!hold && guard == 20) START = 1'b1;
            if (!hold && guard == 22) START = 1'b0;
        end
        repeat (hold ? 40 : 8) @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        armed = 1'b0;
        check({tag, " writes"}, 64'(writes), 64'd16);
        check({tag, " first_addr_w_lat"}, 64'(first_ew - start_edge), 64'd1);
        check({tag, " last_write_lat"}, 64'(last_wr - start_edge), 64'd42);
        for (int w = 0; w < 16; w++) begin
            check($sformatf("%s word%0d", tag, w), omem[w], exp_mem[w]);
        end
    endtask

    function automatic logic [79:0] ctl_snapshot();
        return {EN_W, EN_I, EN_O, RW_O, ADDR_W, ADDR_I, ADDR_O, WDATA_O, 2'b00};
    endfunction

    initial begin
        int guard;
        RSTN  = 1'b1;
        START = 1'b0;
        MNT   = '0;
        fill('0, '0);
        repeat (3) @(negedge CLK);
        check("reset ctl", ctl_snapshot()[79:16], 64'd0);
        check("reset wdata", WDATA_O, 64'd0);
        RSTN = 1'b0;
        @(negedge CLK);
        check("idle ctl", ctl_snapshot()[79:16], 64'd0);

        fill({8{8'h01}}, {8{8'h02}});
        run_pass(12'h373, 1'b0, "p373");
        check("p373 lit w0", omem[0], 64'h000E_000E_000E_0000);
        check("p373 lit w6", omem[6], 64'h0);

        fill({8{8'hFF}}, {8{8'h05}});
        run_pass(12'h888, 1'b0, "p888neg");
        check("p888neg lit w15", omem[15], 64'hFFD8_FFD8_FFD8_FFD8);

        fill({8{8'h7F}}, {8{8'h7F}});
        run_pass(12'h888, 1'b0, "p888max");
`ifdef MAC_SATURATE_EN
        check("p888max lit w7", omem[7], 64'h7FFF_7FFF_7FFF_7FFF);
`else
        check("p888max lit w7", omem[7], 64'hF808_F808_F808_F808);
`endif

        fill_random();
        run_pass(12'h088, 1'b1, "pM0held");
        check("pM0held lit w3", omem[3], 64'h0);

        // Reset in the middle of a pass (low-half write of row 2)
        fill({8{8'h01}}, {8{8'h02}});
        @(negedge CLK);
        MNT   = 12'h373;
        START = 1'b1;
        guard = 0;
        while (!(EN_O && ADDR_O == 4'd4) && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check("rst reached wlo t2", 64'(guard < 100), 64'd1);
        RSTN  = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        RSTN = 1'b0;
        check("midpass rst ctl", ctl_snapshot()[79:16], 64'd0);
        check("midpass rst wdata", WDATA_O, 64'd0);
        @(negedge CLK);
        check("midpass rst stays idle", ctl_snapshot()[79:16], 64'd0);
        run_pass(12'h373, 1'b0, "rerun373");
        check("rerun373 lit w0", omem[0], 64'h000E_000E_000E_0000);

        fill_random();
        imem[0] = {8{8'h80}};
        wmem[0] = {8{8'h80}};
        run_pass(12'h111, 1'b0, "p111");
        check("p111 lit w0", omem[0], 64'h4000_0000_0000_0000);

        for (int p = 0; p < 4; p++) begin
            fill_random();
            run_pass(12'($urandom), 1'b0, $sformatf("rand%0d", p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mac_array
`default_nettype wire
